// File: rtl/pool_sched_ctrl.sv
// rtl/pool_sched_ctrl.sv - pooling window sequencer between feature SRAM and pool_window
//
// Walks a square image in a synchronous-read feature memory, gathers each
// non-overlapping ws x ws window into a window buffer, offers it to the
// pool_window unit with a valid/ready handshake and writes each pooled result
// to the output memory. Trailing rows/cols that do not fill a window are skipped.
//
// Ports:
//   clk_i, reset_ni          clock (rising edge), asynchronous active-low reset
//   start_i                  one-cycle start pulse, accepted only in IDLE
//   img_size_i, window_size_i  job configuration, sampled on accepted start
//   busy_o, done_o, err_o    job status; done/err are one-cycle pulses
//   mem_addr_o, mem_rd_o     feature memory read port
//   mem_rdata_i              read data, valid the cycle after mem_rd_o
//   win_data_o, win_size_o   window buffer and window side to pool_window
//   win_valid_o, win_ready_i window handshake
//   pool_result_i            pooled value, sampled at handshake
//   out_addr_o, out_data_o, out_we_o  output memory write port
module pool_sched_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 10,
  parameter int MAX_IMG = 32,
  parameter int MAX_WIN = 5
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     start_i,
  input  logic [15:0]              img_size_i,
  input  logic [15:0]              window_size_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic                     mem_rd_o,
  input  logic signed [DATA_W-1:0] mem_rdata_i,
  output logic signed [DATA_W-1:0] win_data_o [0:MAX_WIN*MAX_WIN-1],
  output logic [15:0]              win_size_o,
  output logic                     win_valid_o,
  input  logic                     win_ready_i,
  input  logic signed [DATA_W-1:0] pool_result_i,
  output logic [ADDR_W-1:0]        out_addr_o,
  output logic signed [DATA_W-1:0] out_data_o,
  output logic                     out_we_o
);

  localparam int WIN_N = MAX_WIN * MAX_WIN;
  localparam int IDX_W = $clog2(WIN_N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_PRESENT,
    S_DONE
  } state_e;

  state_e state_q, state_d;
  logic [15:0] img_q, img_d;
  logic [15:0] ws_q, ws_d;
  logic        err_q, err_d;
  // Tile origin (row i, col j) and position (r, c) inside the window.
  logic [15:0] i_q, i_d, j_q, j_d;
  logic [15:0] r_q, r_d, c_q, c_d;
  logic [ADDR_W-1:0] tile_q, tile_d;
  // A read issued last cycle lands in the buffer at cap_idx this cycle.
  logic             cap_vld_q, cap_vld_d;
  logic [IDX_W-1:0] cap_idx_q, cap_idx_d;
  logic signed [DATA_W-1:0] win_q [0:WIN_N-1];
  logic signed [DATA_W-1:0] win_d [0:WIN_N-1];

  logic        cfg_ok;
  logic        tile_init;
  logic        row_end;
  logic        last_tile;
  logic [15:0] idx_full;
  logic [15:0] ws_sq;

  assign cfg_ok = (window_size_i >= 16'd1) && (window_size_i <= 16'(MAX_WIN)) &&
                  (img_size_i >= 16'd1) && (img_size_i <= 16'(MAX_IMG)) &&
                  (window_size_i <= img_size_i);

  // No further full window fits to the right / below the current one.
  assign row_end   = (j_q + (ws_q << 1)) > img_q;
  assign last_tile = row_end && ((i_q + (ws_q << 1)) > img_q);
  assign idx_full  = r_q * ws_q + c_q;

  always_comb begin
    state_d     = state_q;
    img_d       = img_q;
    ws_d        = ws_q;
    err_d       = err_q;
    i_d         = i_q;
    j_d         = j_q;
    r_d         = r_q;
    c_d         = c_q;
    tile_d      = tile_q;
    cap_vld_d   = 1'b0;
    cap_idx_d   = cap_idx_q;
    tile_init   = 1'b0;
    busy_o      = (state_q != S_IDLE);
    done_o      = 1'b0;
    err_o       = 1'b0;
    mem_rd_o    = 1'b0;
    mem_addr_o  = '0;
    win_valid_o = 1'b0;
    out_we_o    = 1'b0;
    out_addr_o  = '0;
    out_data_o  = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          img_d  = img_size_i;
          ws_d   = window_size_i;
          i_d    = '0;
          j_d    = '0;
          r_d    = '0;
          c_d    = '0;
          tile_d = '0;
          if (cfg_ok) begin
            err_d     = 1'b0;
            tile_init = 1'b1;
            state_d   = S_FETCH;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_FETCH: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = ADDR_W'((i_q + r_q) * img_q + j_q + c_q);
        cap_vld_d  = 1'b1;
        cap_idx_d  = idx_full[IDX_W-1:0];
        if (c_q == ws_q - 16'd1) begin
          c_d = '0;
          if (r_q == ws_q - 16'd1) begin
            r_d     = '0;
            state_d = S_DRAIN;
          end else begin
            r_d = r_q + 16'd1;
          end
        end else begin
          c_d = c_q + 16'd1;
        end
      end

      S_DRAIN: begin
        state_d = S_PRESENT;
      end

      S_PRESENT: begin
        win_valid_o = 1'b1;
        if (win_ready_i) begin
          out_we_o   = 1'b1;
          out_addr_o = tile_q;
          out_data_o = pool_result_i;
          if (last_tile) begin
            state_d = S_DONE;
          end else begin
            tile_d    = tile_q + ADDR_W'(1);
            tile_init = 1'b1;
            state_d   = S_FETCH;
            if (row_end) begin
              j_d = '0;
              i_d = i_q + ws_q;
            end else begin
              j_d = j_q + ws_q;
            end
          end
        end
      end

      S_DONE: begin
        done_o  = 1'b1;
        err_o   = err_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Window buffer: entries beyond ws*ws are cleared when a tile starts so the
  // pooling unit never sees stale data from an earlier, larger window.
  always_comb begin
    win_d = win_q;
    ws_sq = ws_d * ws_d;
    for (int k = 0; k < WIN_N; k++) begin
      if (tile_init && (16'(k) >= ws_sq)) begin
        win_d[k] = '0;
      end else if (cap_vld_q && (cap_idx_q == IDX_W'(k))) begin
        win_d[k] = mem_rdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      img_q     <= '0;
      ws_q      <= '0;
      err_q     <= 1'b0;
      i_q       <= '0;
      j_q       <= '0;
      r_q       <= '0;
      c_q       <= '0;
      tile_q    <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      for (int k = 0; k < WIN_N; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      img_q     <= img_d;
      ws_q      <= ws_d;
      err_q     <= err_d;
      i_q       <= i_d;
      j_q       <= j_d;
      r_q       <= r_d;
      c_q       <= c_d;
      tile_q    <= tile_d;
      cap_vld_q <= cap_vld_d;
      cap_idx_q <= cap_idx_d;
      win_q     <= win_d;
    end
  end

  assign win_data_o = win_q;
  assign win_size_o = ws_q;

endmodule

// File: tb/tb_pool_sched_ctrl.sv
// tb/tb_pool_sched_ctrl.sv - scoreboard bench for pool_sched_ctrl
module tb_pool_sched_ctrl;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int WN = 25;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic win_ready = 1'b1;
  logic [15:0] img_size = '0;
  logic [15:0] window_size = '0;
  logic busy, done, err, mem_rd, win_valid, out_we;
  logic [AW-1:0] mem_addr, out_addr;
  logic signed [DW-1:0] mem_rdata = '0;
  logic signed [DW-1:0] pool_result, out_data;
  logic signed [DW-1:0] win_data [0:WN-1];
  logic [15:0] win_size;

  always #5 clk = ~clk;

  pool_sched_ctrl dut (
    .clk_i         (clk),
    .reset_ni      (rst_n),
    .start_i       (start),
    .img_size_i    (img_size),
    .window_size_i (window_size),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err),
    .mem_addr_o    (mem_addr),
    .mem_rd_o      (mem_rd),
    .mem_rdata_i   (mem_rdata),
    .win_data_o    (win_data),
    .win_size_o    (win_size),
    .win_valid_o   (win_valid),
    .win_ready_i   (win_ready),
    .pool_result_i (pool_result),
    .out_addr_o    (out_addr),
    .out_data_o    (out_data),
    .out_we_o      (out_we)
  );

  // Synchronous-read feature memory.
  logic signed [DW-1:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  // Max-pool unit over the active ws*ws entries.
  always_comb begin
    pool_result = win_data[0];
    for (int k = 1; k < WN; k++) begin
      if ((k < int'(win_size) * int'(win_size)) && (win_data[k] > pool_result))
        pool_result = win_data[k];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int exp_rd[$];
  int exp_wr_addr[$];
  int exp_wr_data[$];
  int exp_done_err[$];
  int exp_done_lat[$];
  int ea, ed, ee, el;
  logic stalled = 1'b0;
  logic hold_bad;
  logic stale_bad;
  logic signed [DW-1:0] snap [0:WN-1];

  int a44 [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
  int r44 [4]  = '{5, 7, 13, 15};
  int a55 [16] = '{0, 1, 5, 6, 2, 3, 7, 8, 10, 11, 15, 16, 12, 13, 17, 18};
  int r55 [4]  = '{6, 8, 16, 18};

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops expectations whenever the DUT presents an event.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      busy_cnt = 0;
      stalled  = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (stalled) begin
        hold_bad = !win_valid;
        for (int k = 0; k < WN; k++) if (win_data[k] !== snap[k]) hold_bad = 1'b1;
        checks++;
        if (hold_bad) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d win_valid=%0b data_changed=%0b required valid=1 stable", cyc, win_valid, hold_bad);
        end
      end
      stalled = win_valid && !win_ready;
      if (stalled) for (int k = 0; k < WN; k++) snap[k] = win_data[k];

      if (mem_rd) begin
        checks++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL mem_rd_unexpected cyc=%0d addr=%0d required no read", cyc, mem_addr);
        end else begin
          ea = exp_rd.pop_front();
          if (int'(mem_addr) != ea) begin
            errors++;
            $display("FAIL mem_addr cyc=%0d got %0d required %0d", cyc, mem_addr, ea);
          end
        end
      end

      if (out_we) begin
        stale_bad = 1'b0;
        for (int k = 0; k < WN; k++)
          if ((k >= int'(win_size) * int'(win_size)) && (win_data[k] != 0)) stale_bad = 1'b1;
        checks++;
        if (exp_wr_addr.size() == 0) begin
          errors++;
          $display("FAIL out_we_unexpected cyc=%0d addr=%0d data=%0d required no write", cyc, out_addr, out_data);
        end else begin
          ea = exp_wr_addr.pop_front();
          ed = exp_wr_data.pop_front();
          if (int'(out_addr) != ea || int'(out_data) != ed || stale_bad) begin
            errors++;
            $display("FAIL out_write cyc=%0d got addr=%0d data=%0d stale=%0b required addr=%0d data=%0d stale=0",
                     cyc, out_addr, out_data, stale_bad, ea, ed);
          end
        end
      end

      if (done) begin
        done_cnt++;
        checks++;
        if (exp_done_err.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected cyc=%0d err=%0b required no done", cyc, err);
        end else begin
          ee = exp_done_err.pop_front();
          el = exp_done_lat.pop_front();
          if (int'(err) != ee || (cyc - start_cyc) != el || busy_cnt != el) begin
            errors++;
            $display("FAIL done got err=%0b latency=%0d busy_cycles=%0d required err=%0d latency=%0d busy_cycles=%0d",
                     err, cyc - start_cyc, busy_cnt, ee, el, el);
          end
        end
        busy_cnt = 0;
      end else if (err) begin
        checks++;
        errors++;
        $display("FAIL err_without_done cyc=%0d got err=1 required 0", cyc);
      end
    end
  end

  task automatic push_job(input int which, input int lat);
    for (int k = 0; k < 16; k++) exp_rd.push_back(which == 4 ? a44[k] : a55[k]);
    for (int k = 0; k < 4; k++) begin
      exp_wr_addr.push_back(k);
      exp_wr_data.push_back(which == 4 ? r44[k] : r55[k]);
    end
    exp_done_err.push_back(0);
    exp_done_lat.push_back(lat);
  endtask

  task automatic do_start(input int img, input int ws);
    @(posedge clk); #1;
    img_size    = 16'(img);
    window_size = 16'(ws);
    start       = 1'b1;
    start_cyc   = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int prev, input string name);
    int k;
    k = 0;
    while (done_cnt == prev && k < 200) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (done_cnt == prev) begin
      errors++;
      $display("FAIL %s done_timeout got no done required done within 200 cycles", name);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_rd.size() != 0 || exp_wr_addr.size() != 0 || exp_done_err.size() != 0) begin
      errors++;
      $display("FAIL %s leftover got rd=%0d wr=%0d done=%0d required 0 0 0",
               name, exp_rd.size(), exp_wr_addr.size(), exp_done_err.size());
    end
    exp_rd.delete();
    exp_wr_addr.delete();
    exp_wr_data.delete();
    exp_done_err.delete();
    exp_done_lat.delete();
  endtask

  task automatic check_idle(input string name);
    logic wbad;
    wbad = 1'b0;
    for (int k = 0; k < WN; k++) if (win_data[k] !== '0) wbad = 1'b1;
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++;
      $display("FAIL %s status got busy=%0b done=%0b err=%0b required 0 0 0", name, busy, done, err);
    end
    checks++;
    if (mem_rd !== 1'b0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL %s mem_port got rd=%0b addr=%0d required 0 0", name, mem_rd, mem_addr);
    end
    checks++;
    if (win_valid !== 1'b0 || win_size !== '0 || wbad) begin
      errors++;
      $display("FAIL %s window got valid=%0b size=%0d data_nonzero=%0b required 0 0 0", name, win_valid, win_size, wbad);
    end
    checks++;
    if (out_we !== 1'b0 || out_addr !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL %s out_port got we=%0b addr=%0d data=%0d required 0 0 0", name, out_we, out_addr, out_data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got simulation still running required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    for (int k = 0; k < 1024; k++) mem[k] = 16'(k);
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;

    // 4x4, ws=2, ready always high.
    push_job(4, 25);
    prev = done_cnt;
    do_start(4, 2);
    wait_done(prev, "img4_ws2");
    check_drained("img4_ws2");

    // Same, consumer stalls tile 1 for three cycles.
    push_job(4, 28);
    prev = done_cnt;
    do_start(4, 2);
    repeat (11) @(posedge clk);
    #1 win_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 win_ready = 1'b1;
    wait_done(prev, "img4_stall");
    check_drained("img4_stall");

    // 5x5, ws=2: trailing row/col skipped.
    push_job(5, 25);
    prev = done_cnt;
    do_start(5, 2);
    wait_done(prev, "img5_ws2");
    check_drained("img5_ws2");

    // Illegal configurations.
    exp_done_err.push_back(1); exp_done_lat.push_back(1);
    prev = done_cnt;
    do_start(4, 0);
    wait_done(prev, "ws0");
    check_drained("ws0");
    exp_done_err.push_back(1); exp_done_lat.push_back(1);
    prev = done_cnt;
    do_start(8, 6);
    wait_done(prev, "ws6");
    check_drained("ws6");
    exp_done_err.push_back(1); exp_done_lat.push_back(1);
    prev = done_cnt;
    do_start(3, 4);
    wait_done(prev, "img3_ws4");
    check_drained("img3_ws4");

    // 3x3, ws=1 with a stray start mid-run.
    for (int k = 0; k < 9; k++) begin
      exp_rd.push_back(k);
      exp_wr_addr.push_back(k);
      exp_wr_data.push_back(k);
    end
    exp_done_err.push_back(0); exp_done_lat.push_back(28);
    prev = done_cnt;
    do_start(3, 1);
    repeat (5) @(posedge clk);
    #1;
    img_size = 16'd4; window_size = 16'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(prev, "img3_ws1");
    check_drained("img3_ws1");

    // Reset during FETCH of tile 2: tiles 0,1 complete, one read of tile 2.
    for (int k = 0; k < 9; k++) exp_rd.push_back(a44[k]);
    exp_wr_addr.push_back(0); exp_wr_data.push_back(5);
    exp_wr_addr.push_back(1); exp_wr_data.push_back(7);
    prev = done_cnt;
    do_start(4, 2);
    repeat (13) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_idle("abort");
    check_drained("abort");
    checks++;
    if (done_cnt != prev) begin
      errors++;
      $display("FAIL abort_done got %0d done pulses required 0", done_cnt - prev);
    end
    @(posedge clk); #1 rst_n = 1'b1;

    // Full job from tile 0 after reset release.
    push_job(4, 25);
    prev = done_cnt;
    do_start(4, 2);
    wait_done(prev, "after_reset");
    check_drained("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
